// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer slice:
//   - default datapath widths (data, register-file depth, index, flags)
//   - ALU flag bit positions inside the {Z, N, C, V} flag vector
//   - FSM state encoding (IDLE -> READ -> EXEC -> WRITE -> IDLE)
//   - sign-extension helper for the 3-bit immediate
// Optional feature macro used by the slice: ALU_SEQ_FLAGS_EN
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int ALU_SEQ_DATA_W = 16;
  localparam int ALU_SEQ_REG_N  = 8;
  localparam int ALU_SEQ_IDX_W  = 3;
  localparam int ALU_SEQ_FLAG_W = 4;

  // Flag vector is ordered {Z, N, C, V}, so Z is the MSB.
  localparam int FLAG_Z_BIT = 3;
  localparam int FLAG_N_BIT = 2;
  localparam int FLAG_C_BIT = 1;
  localparam int FLAG_V_BIT = 0;

  // Sequencer state encoding. Kept as plain constants so the encoding is
  // stable for legacy tools and debug scripts that decode the raw value.
  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE  = 2'd0;
  localparam seq_state_t ST_READ  = 2'd1;
  localparam seq_state_t ST_EXEC  = 2'd2;
  localparam seq_state_t ST_WRITE = 2'd3;

  // Sign-extend a 3-bit immediate to the default data width.
  function automatic logic [ALU_SEQ_DATA_W-1:0] sext_imm3(input logic [2:0] imm);
    return {{(ALU_SEQ_DATA_W-3){imm[2]}}, imm};
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
// REG_N x DATA_W register file for the ALU sequencer.
//   - two asynchronous read ports (operand A / operand B)
//   - one asynchronous debug read port
//   - one synchronous write port; writes to index 0 are dropped
//   - index 0 always reads as zero
//   - asynchronous active-low reset clears every entry
// Ports:
//   clk, rst_n             clock, async active-low reset
//   ra_addr/ra_data        operand A read port
//   rb_addr/rb_data        operand B read port
//   dbg_addr/dbg_data      debug read port
//   we, waddr, wdata       write port
// -----------------------------------------------------------------------------
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = ALU_SEQ_DATA_W,
  parameter int REG_N  = ALU_SEQ_REG_N,
  parameter int IDX_W  = ALU_SEQ_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [IDX_W-1:0]  rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem_q [REG_N];
  logic [DATA_W-1:0] mem_d [REG_N];

  // Next-state of the storage array: apply the single write, never to r0.
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != {IDX_W{1'b0}})) begin
      mem_d[waddr] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // r0 is hardwired to zero on every read port, independent of storage.
  assign ra_data  = (ra_addr  == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : mem_q[ra_addr];
  assign rb_data  = (rb_addr  == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : mem_q[rb_addr];
  assign dbg_data = (dbg_addr == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller that drives a shared external ALU. One instruction
// at a time is accepted over a valid/ready handshake, its operands are read
// from an internal register file (or a sign-extended 3-bit immediate for B),
// the ALU result is sampled and written back.
//
// Sequence: accept at edge N, READ, EXEC, WRITE (done high), IDLE again,
// so the next accept can happen at edge N+4.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        instruction handshake
//   in_opcode                  ALU opcode, passed through unchanged
//   in_rd, in_rs1, in_rs2      destination / source indices
//   in_imm_sel                 use sign-extended in_rs2 as operand B
//   alu_a, alu_b, alu_op       ALU inputs (held outside EXEC)
//   alu_result, alu_flags      combinational ALU outputs
//   result                     last written-back value
//   done                       one-cycle pulse during WRITE
//   busy                       high whenever not IDLE
//   dbg_addr / dbg_data        debug register-file read
//   flags                      (ALU_SEQ_FLAGS_EN only) flags captured in EXEC
//
// Build option: define ALU_SEQ_FLAGS_EN to add the flags register and port.
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = ALU_SEQ_DATA_W,
  parameter int REG_N  = ALU_SEQ_REG_N,
  parameter int FLAG_W = ALU_SEQ_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic              in_imm_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] flags
`endif
);

  // Architectural and pipeline state.
  seq_state_t        state_q,     state_d;
  logic [7:0]        opcode_q,    opcode_d;
  logic [2:0]        rd_q,        rd_d;
  logic [2:0]        rs1_q,       rs1_d;
  logic [2:0]        rs2_q,       rs2_d;
  logic              imm_sel_q,   imm_sel_d;
  logic [DATA_W-1:0] opa_q,       opa_d;
  logic [DATA_W-1:0] opb_q,       opb_d;
  logic [7:0]        alu_op_q,    alu_op_d;
  logic [DATA_W-1:0] res_q,       res_d;
  logic [DATA_W-1:0] result_q,    result_d;
  logic              done_q,      done_d;
  logic              in_ready_q,  in_ready_d;
  logic              busy_q,      busy_d;

  // Register-file connections.
  logic [DATA_W-1:0] rf_a_data_s;
  logic [DATA_W-1:0] rf_b_data_s;
  logic              rf_we_s;
  logic [DATA_W-1:0] imm_ext_s;

  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .IDX_W  (3)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (rs1_q),
    .ra_data  (rf_a_data_s),
    .rb_addr  (rs2_q),
    .rb_data  (rf_b_data_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we_s),
    .waddr    (rd_q),
    .wdata    (res_q)
  );

  // The immediate lives in the rs2 field; extend it from its top bit.
  assign imm_ext_s = {{(DATA_W-3){rs2_q[2]}}, rs2_q};

  // Write-back happens on the edge that leaves WRITE; r0 is filtered in the file.
  assign rf_we_s = (state_q == ST_WRITE);

  // FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_sel_d = imm_sel_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    alu_op_d  = alu_op_q;
    res_d     = res_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          opcode_d  = in_opcode;
          rd_d      = in_rd;
          rs1_d     = in_rs1;
          rs2_d     = in_rs2;
          imm_sel_d = in_imm_sel;
          state_d   = ST_READ;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_READ: begin
        // Operands and opcode move to the ALU-facing registers together so
        // alu_a/alu_b/alu_op only change on entry to EXEC.
        opa_d    = rf_a_data_s;
        if (imm_sel_q) begin
          opb_d  = imm_ext_s;
        end else begin
          opb_d  = rf_b_data_s;
        end
        alu_op_d = opcode_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_result;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        result_d = res_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies,
    // so they line up exactly with state_q.
    done_d     = (state_d == ST_WRITE);
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Sequencer state flops; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 8'h00;
      rd_q       <= 3'd0;
      rs1_q      <= 3'd0;
      rs2_q      <= 3'd0;
      imm_sel_q  <= 1'b0;
      opa_q      <= {DATA_W{1'b0}};
      opb_q      <= {DATA_W{1'b0}};
      alu_op_q   <= 8'h00;
      res_q      <= {DATA_W{1'b0}};
      result_q   <= {DATA_W{1'b0}};
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_sel_q  <= imm_sel_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      alu_op_q   <= alu_op_d;
      res_q      <= res_d;
      result_q   <= result_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign alu_a    = opa_q;
  assign alu_b    = opb_q;
  assign alu_op   = alu_op_q;
  assign result   = result_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic [FLAG_W-1:0] flags_q, flags_d;

  // Flags are sampled with the result at the end of EXEC and then held.
  always_comb begin
    if (state_q == ST_EXEC) begin
      flags_d = alu_flags;
    end else begin
      flags_d = flags_q;
    end
  end

  // Flags register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= {FLAG_W{1'b0}};
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`else
  // Without the flags option the ALU flag bus is intentionally ignored.
  logic unused_alu_flags_s;
  assign unused_alu_flags_s = ^alu_flags;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer with an ALU stub
// (8'h01 = A+B, 8'h02 = A-B, Z set when result is zero).
// A register-file model tracks expected contents instruction by instruction.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_opcode;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic        in_imm_sel;
  logic [15:0] alu_a, alu_b;
  logic [7:0]  alu_op;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] m_rf [8];

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        imm;
    logic [15:0] exp;
  } vec_t;

  vec_t tab [5];

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm_sel (in_imm_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .result     (result),
    .done       (done),
    .busy       (busy),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags      (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub.
  always_comb begin
    case (alu_op)
      8'h01:   alu_result = alu_a + alu_b;
      8'h02:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_flags = {(alu_result == 16'h0000), alu_result[15], 1'b0, 1'b0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all_regs(input string nm);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = a[2:0];
      #1;
      chk(nm, dbg_data, m_rf[a]);
    end
  endtask

  // Issue one instruction and check timing, ALU drive, result and write-back.
  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic imm,
                       input logic use_tab, input logic [15:0] tab_exp);
    logic [15:0] ea, eb, er, exp_r;
    int cnt;
    int lat;
    ea = (rs1 == 3'd0) ? 16'h0000 : m_rf[rs1];
    if (imm) eb = {{13{rs2[2]}}, rs2};
    else     eb = (rs2 == 3'd0) ? 16'h0000 : m_rf[rs2];
    er = (op == 8'h01) ? (ea + eb) : (ea - eb);
    exp_r = use_tab ? tab_exp : er;

    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm_sel = imm;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("accept_wait", (cnt < 20) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        chk("busy_in_flight", busy, 1'b1);
        chk("ready_low_in_flight", in_ready, 1'b0);
      end
      if (k == 2) begin
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_op", alu_op, op);
      end
      if (done) lat = k;
    end
    chk("done_latency", lat, 3);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("ready_after", in_ready, 1'b1);
    chk("result", result, exp_r);
    dbg_addr = rd;
    #1;
    chk("writeback", dbg_data, (rd == 3'd0) ? 16'h0000 : exp_r);
`ifdef ALU_SEQ_FLAGS_EN
    chk("flag_z", flags[FLAG_Z_BIT], (exp_r == 16'h0000));
`endif
    if (rd != 3'd0) m_rf[rd] = er;
  endtask

  logic [7:0]  hs_op  [3];
  logic [2:0]  hs_rd  [3];
  logic [2:0]  hs_rs1 [3];
  logic [2:0]  hs_rs2 [3];
  logic        hs_imm [3];
  int          acc_cyc [3];

  initial begin
    tab[0] = '{op: 8'h01, rd: 3'd1, rs1: 3'd0, rs2: 3'b011, imm: 1'b1, exp: 16'h0003};
    tab[1] = '{op: 8'h01, rd: 3'd2, rs1: 3'd0, rs2: 3'b111, imm: 1'b1, exp: 16'hFFFF};
    tab[2] = '{op: 8'h01, rd: 3'd3, rs1: 3'd1, rs2: 3'd2,   imm: 1'b0, exp: 16'h0002};
    tab[3] = '{op: 8'h02, rd: 3'd3, rs1: 3'd3, rs2: 3'd3,   imm: 1'b0, exp: 16'h0000};
    tab[4] = '{op: 8'h01, rd: 3'd0, rs1: 3'd1, rs2: 3'd1,   imm: 1'b1, exp: 16'h0004};

    for (int a = 0; a < 8; a++) m_rf[a] = 16'h0000;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 8'h00; in_rd = 3'd0; in_rs1 = 3'd0;
    in_rs2 = 3'd0; in_imm_sel = 1'b0; dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_op", alu_op, 8'h00);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_ready", in_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
    end
    check_all_regs("idle_regs");

    // Directed table: immediates, dependent chain, write to r0.
    for (int i = 0; i < 5; i++) begin
      issue(tab[i].op, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm, 1'b1, tab[i].exp);
    end
    check_all_regs("table_regs");

    // Handshake: in_valid held high across three instructions.
    for (int i = 0; i < 3; i++) begin
      hs_op[i]  = 8'h01;
      hs_rd[i]  = 3'($urandom_range(1, 7));
      hs_rs1[i] = 3'($urandom_range(0, 7));
      hs_rs2[i] = 3'($urandom_range(0, 7));
      hs_imm[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_opcode = hs_op[0]; in_rd = hs_rd[0]; in_rs1 = hs_rs1[0];
    in_rs2 = hs_rs2[0]; in_imm_sel = hs_imm[0];
    begin
      int accepts;
      logic [15:0] ea, eb;
      accepts = 0;
      for (int c = 0; c < 40 && accepts < 3; c++) begin
        if (c > 0) @(negedge clk);
        if (in_ready) begin
          acc_cyc[accepts] = c;
          ea = (hs_rs1[accepts] == 3'd0) ? 16'h0000 : m_rf[hs_rs1[accepts]];
          if (hs_imm[accepts]) eb = {{13{hs_rs2[accepts][2]}}, hs_rs2[accepts]};
          else eb = (hs_rs2[accepts] == 3'd0) ? 16'h0000 : m_rf[hs_rs2[accepts]];
          m_rf[hs_rd[accepts]] = ea + eb;
          accepts++;
          @(posedge clk);
          #1;
          if (accepts < 3) begin
            in_opcode = hs_op[accepts]; in_rd = hs_rd[accepts]; in_rs1 = hs_rs1[accepts];
            in_rs2 = hs_rs2[accepts]; in_imm_sel = hs_imm[accepts];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      in_valid = 1'b0;
      chk("hs_accept_count", accepts, 3);
      if (accepts == 3) begin
        chk("hs_gap1", acc_cyc[1] - acc_cyc[0], 4);
        chk("hs_gap2", acc_cyc[2] - acc_cyc[1], 4);
      end
    end
    repeat (5) @(negedge clk);
    chk("hs_result", result, m_rf[hs_rd[2]]);
    check_all_regs("hs_regs");

    // Randomised instructions against the model.
    for (int i = 0; i < 16; i++) begin
      issue(8'($urandom_range(1, 2)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
    end
    check_all_regs("rand_regs");

    // Reset during EXEC of an instruction targeting r5.
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 8'h01; in_rd = 3'd5; in_rs1 = 3'd0; in_rs2 = 3'd1; in_imm_sel = 1'b1;
    begin
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("mid_accept_wait", (cnt < 20) ? 32'd1 : 32'd0, 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_exec_op", alu_op, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_alu_a", alu_a, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) m_rf[a] = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_ready", in_ready, 1'b1);
    end
    chk("post_rst_result", result, 16'h0000);
    check_all_regs("post_rst_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
